// File: rtl/sqrt_pkg.sv
// Shared constants for the integer square-root engine: FSM encoding and
// datapath algorithm selectors.
package sqrt_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ITER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int unsigned MODE_ODD_SUM = 0;
  localparam int unsigned MODE_DIGIT   = 1;

endpackage

// File: rtl/sqrt_datapath.sv
// Square-root datapath: odd-sum search or restoring digit-by-digit iteration,
// plus the result registers that hold root/remainder between results.
module sqrt_datapath
  import sqrt_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned MODE  = MODE_DIGIT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   radicand_i,
  output logic               last_c,
  output logic [WIDTH/2-1:0] root_o,
  output logic [WIDTH/2:0]   rem_o
);

  localparam int unsigned HW = WIDTH / 2;

  logic [HW-1:0] res_root_c;
  logic [HW:0]   res_rem_c;

  generate
    if (MODE == MODE_ODD_SUM) begin : g_odd_sum
      // Invariant: sq_q = (r_q+1)^2, delta_q = 2*r_q+3
      logic [WIDTH-1:0] a_q;
      logic [HW-1:0]    r_q;
      logic [WIDTH:0]   sq_q;
      logic [HW+1:0]    delta_q;
      logic             fits_c;
      logic [WIDTH:0]   prev_sq_c;

      assign fits_c    = sq_q <= {1'b0, a_q};
      assign prev_sq_c = sq_q - (WIDTH+1)'(delta_q) + (WIDTH+1)'(2);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q     <= '0;
          r_q     <= '0;
          sq_q    <= '0;
          delta_q <= '0;
        end else if (load_i) begin
          a_q     <= radicand_i;
          r_q     <= '0;
          sq_q    <= (WIDTH+1)'(1);
          delta_q <= (HW+2)'(3);
        end else if (step_i && fits_c) begin
          r_q     <= r_q + HW'(1);
          sq_q    <= sq_q + (WIDTH+1)'(delta_q);
          delta_q <= delta_q + (HW+2)'(2);
        end
      end

      assign last_c     = !fits_c;
      assign res_root_c = r_q;
      assign res_rem_c  = (HW+1)'({1'b0, a_q} - prev_sq_c);
    end else begin : g_digit
      localparam int unsigned CW = (HW > 1) ? $clog2(HW) : 1;

      logic [WIDTH-1:0] sh_q;
      logic [HW-1:0]    r_q;
      logic [HW:0]      part_q;
      logic [CW-1:0]    cnt_q;
      logic [HW+2:0]    shifted_c;
      logic [HW+2:0]    trial_c;
      logic             ge_c;
      logic [HW:0]      diff_c;
      logic [HW-1:0]    r_next_c;

      // Bring down the next radicand bit pair and try subtracting 4r+1
      assign shifted_c = {part_q, sh_q[WIDTH-1 -: 2]};
      assign trial_c   = {1'b0, r_q, 2'b01};
      assign ge_c      = shifted_c >= trial_c;
      assign diff_c    = ge_c ? (HW+1)'(shifted_c - trial_c) : shifted_c[HW:0];
      assign r_next_c  = {r_q[HW-2:0], ge_c};

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sh_q   <= '0;
          r_q    <= '0;
          part_q <= '0;
          cnt_q  <= '0;
        end else if (load_i) begin
          sh_q   <= radicand_i;
          r_q    <= '0;
          part_q <= '0;
          cnt_q  <= '0;
        end else if (step_i) begin
          sh_q   <= {sh_q[WIDTH-3:0], 2'b00};
          r_q    <= r_next_c;
          part_q <= diff_c;
          cnt_q  <= cnt_q + CW'(1);
        end
      end

      assign last_c     = cnt_q == CW'(HW - 1);
      assign res_root_c = r_next_c;
      assign res_rem_c  = diff_c;
    end
  endgenerate

  // Results only change on the final iteration edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      root_o <= '0;
      rem_o  <= '0;
    end else if (step_i && last_c) begin
      root_o <= res_root_c;
      rem_o  <= res_rem_c;
    end
  end

endmodule

// File: rtl/sqrt_engine.sv
// Integer square-root engine: IDLE/ITER/DONE control around sqrt_datapath,
// with registered busy/valid status.
module sqrt_engine
  import sqrt_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned MODE  = MODE_DIGIT
) (
  input  logic               clock,
  input  logic               clear_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   radicand,
  output logic               busy,
  output logic               valid,
  output logic [WIDTH/2-1:0] root,
  output logic [WIDTH/2:0]   remainder
);

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       accept_c;
  logic       step_c;
  logic       last_c;

  assign accept_c = start && (state_q != ST_ITER);
  assign step_c   = state_q == ST_ITER;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_ITER;
      ST_ITER: if (last_c) state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_ITER : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Status flags are registered alongside the state they decode
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= ST_IDLE;
      busy    <= 1'b0;
      valid   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= state_d == ST_ITER;
      valid   <= state_d == ST_DONE;
    end
  end

  sqrt_datapath #(
    .WIDTH(WIDTH),
    .MODE (MODE)
  ) u_datapath (
    .clk       (clock),
    .rst_n     (clear_n),
    .load_i    (accept_c),
    .step_i    (step_c),
    .radicand_i(radicand),
    .last_c    (last_c),
    .root_o    (root),
    .rem_o     (remainder)
  );

endmodule

// File: tb/tb_sqrt_engine.sv
// Directed and exhaustive checks of sqrt_engine in both modes at WIDTH 8 and 16.
module tb_sqrt_engine;

  logic        clock = 1'b0;
  logic        clear_n;
  logic        st [4];
  logic [7:0]  rad8;
  logic [15:0] rad16;

  logic        b0, v0, b1, v1, b2, v2, b3, v3;
  logic [3:0]  r0, r1;
  logic [4:0]  m0, m1;
  logic [7:0]  r2, r3;
  logic [8:0]  m2, m3;

  logic        vld [4];
  logic        bsy [4];
  logic [15:0] rt  [4];
  logic [16:0] rm  [4];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // idx 0: W8 digit, 1: W8 odd-sum, 2: W16 digit, 3: W16 odd-sum
  sqrt_engine #(.WIDTH(8), .MODE(1)) u_w8_digit (
    .clock(clock), .clear_n(clear_n), .start(st[0]), .radicand(rad8),
    .busy(b0), .valid(v0), .root(r0), .remainder(m0));
  sqrt_engine #(.WIDTH(8), .MODE(0)) u_w8_odd (
    .clock(clock), .clear_n(clear_n), .start(st[1]), .radicand(rad8),
    .busy(b1), .valid(v1), .root(r1), .remainder(m1));
  sqrt_engine #(.WIDTH(16), .MODE(1)) u_w16_digit (
    .clock(clock), .clear_n(clear_n), .start(st[2]), .radicand(rad16),
    .busy(b2), .valid(v2), .root(r2), .remainder(m2));
  sqrt_engine #(.WIDTH(16), .MODE(0)) u_w16_odd (
    .clock(clock), .clear_n(clear_n), .start(st[3]), .radicand(rad16),
    .busy(b3), .valid(v3), .root(r3), .remainder(m3));

  always_comb begin
    vld[0] = v0; vld[1] = v1; vld[2] = v2; vld[3] = v3;
    bsy[0] = b0; bsy[1] = b1; bsy[2] = b2; bsy[3] = b3;
    rt[0] = 16'(r0); rt[1] = 16'(r1); rt[2] = 16'(r2); rt[3] = 16'(r3);
    rm[0] = 17'(m0); rm[1] = 17'(m1); rm[2] = 17'(m2); rm[3] = 17'(m3);
  end

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic int isqrt(input int a);
    int r = 0;
    while ((r + 1) * (r + 1) <= a) r++;
    return r;
  endfunction

  // Called at a falling edge; the following rising edge is the accepting edge
  task automatic launch(input int idx, input int a);
    if (idx < 2) rad8 = 8'(a); else rad16 = 16'(a);
    st[idx] = 1'b1;
    @(negedge clock);
    st[idx] = 1'b0;
  endtask

  // Counts edges after acceptance until valid; optionally pulses start mid-ITER
  task automatic wait_done(input int idx, input int glitch, output int n, output int nb);
    n  = 0;
    nb = bsy[idx] ? 1 : 0;
    while (!vld[idx] && n < 400) begin
      if (n == glitch) begin
        st[idx] = 1'b1;
        if (idx < 2) rad8 = 8'd9; else rad16 = 16'd9;
      end
      @(negedge clock);
      st[idx] = 1'b0;
      n++;
      if (bsy[idx]) nb++;
    end
  endtask

  task automatic check_result(input int idx, input string tag, input int n, input int nb,
                              input int er, input int em, input int el);
    check({tag, ".lat"}, n, el);
    check({tag, ".busy"}, nb, el);
    check({tag, ".root"}, rt[idx], er);
    check({tag, ".rem"}, rm[idx], em);
  endtask

  task automatic run(input int idx, input int a, input int er, input int em, input int el,
                     input string tag, input int glitch);
    int n, nb;
    launch(idx, a);
    wait_done(idx, glitch, n, nb);
    check_result(idx, tag, n, nb, er, em, el);
    @(negedge clock);
    check({tag, ".vpulse"}, vld[idx], 0);
    check({tag, ".hold"}, rt[idx], er);
  endtask

  task automatic b2b(input int idx, input int a1, input int r1, input int m1, input int l1,
                     input int a2, input int r2x, input int m2x, input int l2, input string tag);
    int n, nb;
    launch(idx, a1);
    wait_done(idx, -1, n, nb);
    check_result(idx, {tag, ".1"}, n, nb, r1, m1, l1);
    launch(idx, a2);
    check({tag, ".noidle"}, bsy[idx], 1);
    wait_done(idx, -1, n, nb);
    check_result(idx, {tag, ".2"}, n, nb, r2x, m2x, l2);
    @(negedge clock);
  endtask

  initial begin
    int r;
    for (int i = 0; i < 4; i++) st[i] = 1'b0;
    rad8    = '0;
    rad16   = '0;
    clear_n = 1'b0;
    #2;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("init.%0d.busy", i), bsy[i], 0);
      check($sformatf("init.%0d.valid", i), vld[i], 0);
      check($sformatf("init.%0d.root", i), rt[i], 0);
      check($sformatf("init.%0d.rem", i), rm[i], 0);
    end
    repeat (2) @(negedge clock);
    clear_n = 1'b1;
    @(negedge clock);

    run(0, 200, 14, 4, 4, "w8d.200", -1);
    run(1, 200, 14, 4, 15, "w8o.200", -1);
    run(1, 0, 0, 0, 1, "w8o.0", -1);
    run(0, 0, 0, 0, 4, "w8d.0", -1);
    run(1, 144, 12, 0, 13, "w8o.144", -1);
    run(0, 255, 15, 30, 4, "w8d.255", -1);
    run(2, 65535, 255, 510, 8, "w16d.max", -1);
    run(3, 65535, 255, 510, 256, "w16o.max", -1);
    run(2, 65024, 254, 508, 8, "w16d.65024", -1);
    run(3, 65024, 254, 508, 255, "w16o.65024", -1);

    run(1, 200, 14, 4, 15, "w8o.glitch", 3);
    run(0, 200, 14, 4, 4, "w8d.glitch", 1);
    b2b(0, 200, 14, 4, 4, 255, 15, 30, 4, "w8d.b2b");
    b2b(1, 49, 7, 0, 8, 50, 7, 1, 8, "w8o.b2b");

    // Reset during the second ITER cycle of a digit-mode run
    launch(0, 200);
    @(negedge clock);
    #1 clear_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst.%0d.busy", i), bsy[i], 0);
      check($sformatf("rst.%0d.valid", i), vld[i], 0);
      check($sformatf("rst.%0d.root", i), rt[i], 0);
      check($sformatf("rst.%0d.rem", i), rm[i], 0);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check($sformatf("rst.novalid.%0d", k), vld[0], 0);
    end
    clear_n = 1'b1;
    for (int k = 0; k < 3; k++) check($sformatf("rel.novalid.%0d", k), vld[0], 0);
    run(0, 200, 14, 4, 4, "w8d.afterrst", -1);
    run(1, 99, 9, 18, 10, "w8o.afterrst", -1);

    for (int idx = 0; idx < 2; idx++) begin
      for (int a = 0; a < 256; a++) begin
        r = isqrt(a);
        run(idx, a, r, a - r * r, (idx == 0) ? 4 : r + 1, $sformatf("sw%0d.%0d", idx, a), -1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sqrt_engine.md
SQRT_ENGINE -- requirements
Module: sqrt_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 8, radicand width; even, 4..32.
REQ-002 SHALL have parameter MODE, default 1; 0 = incremental odd-sum search, 1 = digit-by-digit restoring.
REQ-003 SHALL have port clock  input  1  single rising-edge clock.
REQ-004 SHALL have port clear_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  request; operand sampled on the accepting edge.
REQ-006 SHALL have port radicand  input  WIDTH  unsigned operand A.
REQ-007 SHALL have port busy  output  1  high while a computation is in progress.
REQ-008 SHALL have port valid  output  1  one-cycle pulse marking a new result.
REQ-009 SHALL have port root  output  WIDTH/2  floor(sqrt(A)).
REQ-010 SHALL have port remainder  output  WIDTH/2+1  A - root^2.

Function
REQ-011 SHALL implement states IDLE, ITER and DONE.
REQ-012 SHALL accept start only in IDLE or DONE, and SHALL ignore start in ITER with no effect on the running operation.
REQ-013 SHALL, on an accepting edge, capture radicand, initialise the datapath and enter ITER.
REQ-014 SHALL initialise MODE 0 datapath as r=0, sq=1, delta=3; sq is WIDTH+1 bits and delta is WIDTH/2+2 bits, with no overflow permitted.
REQ-015 SHALL, in MODE 0 each ITER edge: if sq<=A then r+=1, sq+=delta, delta+=2; otherwise root=r, remainder=A-(sq-delta+2), go to DONE.
REQ-016 SHALL have MODE 0 latency of exactly root+1 edges after acceptance until valid is high.
REQ-017 SHALL, in MODE 1, resolve one root bit per ITER edge, MSB first, by restoring trial subtraction.
REQ-018 SHALL have MODE 1 latency of exactly WIDTH/2 edges after acceptance until valid is high, independent of A.
REQ-019 SHALL hold valid high only during the DONE cycle; DONE returns to IDLE after one cycle unless start re-enters ITER.
REQ-020 SHALL hold busy high exactly while in ITER.
REQ-021 SHALL register root and remainder, keeping them stable from valid until the next result overwrites them; an accepted start does not clear them.
REQ-022 SHALL produce identical root and remainder in both modes for all A in 0..2^WIDTH-1.
REQ-023 SHALL handle boundaries as follows:
- A=0 gives root 0 and remainder 0.
- A=2^WIDTH-1 gives root 2^(WIDTH/2)-1 and remainder 2^(WIDTH/2+1)-2.
- Perfect squares give remainder 0.

Reset
REQ-024 SHALL, on clear_n low, immediately force state IDLE and busy=0, valid=0, root=0, remainder=0, and all internal registers to 0, including mid-ITER.
REQ-025 SHALL, on clear_n low, abandon any in-flight computation; no valid is produced for it.
REQ-026 SHALL release synchronously: the first start is honoured on the first rising edge with clear_n high.

Structure
REQ-027 SHALL place the state encoding (IDLE, ITER, DONE) and the MODE constants (MODE_ODD_SUM=0, MODE_DIGIT=1) in shared package sqrt_pkg.
REQ-028 SHALL split into an FSM in sqrt_engine and one sub-module sqrt_datapath(WIDTH, MODE) holding the A/r/sq/delta or partial-remainder registers and the comparator.
REQ-029 SHALL use one always block for state and a separate combinational next-state block; no latches and no derived clocks.

Verification
REQ-030 SHALL cover: WIDTH=8, MODE=1, A=200 -> root 14, remainder 4, valid after exactly 4 edges, busy high for 4 cycles.
REQ-031 SHALL cover: WIDTH=8, MODE=0, A=200 -> root 14, remainder 4, valid after 15 edges; A=0 -> root 0, remainder 0 after 1 edge.
REQ-032 SHALL cover: WIDTH=16, both modes, A=65535 -> root 255, remainder 510; A=65536-512=65024 -> root 254, remainder 508.
REQ-033 SHALL cover: start pulsed mid-ITER with a different A -> ignored, first result unchanged; start during DONE -> back-to-back result, no idle cycle.
REQ-034 SHALL cover: clear_n low at cycle 2 of ITER -> all outputs 0 at once, no valid pulse; a new start after release -> correct result.
REQ-035 SHALL cover: exhaustive WIDTH=8 sweep, both modes, against a reference model -> zero mismatches.
